mem_bus_arbiter: RTL and testbench

//  Shares the single RAM port between two requesters: port 0 = CPU control unit (fetch/operand

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter_rr_pick2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encodings and port indices.
package mem_arb_defs;

  // Requester indices; also the value carried on owner and stored as "last served".
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  // Transfer sequencer states, encoding is visible on disp_state.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ADDR   = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  // Grant picker: a lone request wins outright, a tie goes to the port not served last.
  function automatic logic rr_winner(input logic [1:0] req, input logic last);
    logic gnt;
    gnt = PORT_CPU;
    case (req)
      2'b10:   gnt = PORT_IO;
      2'b11:   gnt = ~last;
      default: gnt = PORT_CPU;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester handshakes plus the single RAM port.
// slave  : the arbiter side (samples requests, drives acks/read data/RAM controls).
// master : the environment side (requesters and the RAM itself).
interface mem_bus_arbiter_if #(
  parameter int word_width = 16,
  parameter int addr_width = 16
);

  // Port 0 (CPU control unit)
  logic                  req0;
  logic                  we0;
  logic [addr_width-1:0] addr0;
  logic [word_width-1:0] wdata0;
  logic                  ack0;
  logic [word_width-1:0] rdata0;

  // Port 1 (IO/DMA engine)
  logic                  req1;
  logic                  we1;
  logic [addr_width-1:0] addr1;
  logic [word_width-1:0] wdata1;
  logic                  ack1;
  logic [word_width-1:0] rdata1;

  // Shared RAM port
  logic [addr_width-1:0] ram_addr;
  logic [word_width-1:0] ram_wdata;
  logic [word_width-1:0] ram_rdata;
  logic                  ram_oe;
  logic                  ram_we;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output ack0, rdata0, ack1, rdata1,
    output ram_addr, ram_wdata, ram_oe, ram_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_addr, ram_wdata, ram_oe, ram_we
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: who gets the RAM next, and whether anyone asked.
module rr_pick2
  import mem_arb_defs::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt,
  output logic       o_valid
);

  // Winner selection; o_gnt is only meaningful while o_valid is high.
  always_comb begin
    o_valid = |i_req;
    o_gnt   = rr_winner(i_req, i_last);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port RAM arbiter: one word per grant, sequenced as address phase,
// access phase with programmable wait states, then a one-cycle ack.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ARB_IDLE   | no transfer; pick a winner and latch its operands
//  ARB_ADDR   | address/data presented to RAM, strobes low, load wait counter
//  ARB_ACCESS | strobes active; count down wait states, capture read data last
//  ARB_DONE   | ack pulse to the owner, remember it for the next tie
module mem_bus_arbiter
  import mem_arb_defs::*;
#(
  parameter int word_width  = 16,
  parameter int addr_width  = 16,
  parameter int wait_states = 1,
  parameter int state_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_bus_arbiter_if.slave       bus,
  output logic                   busy,
  output logic                   owner,
  output logic [state_width-1:0] disp_state
);

  // Counter is at least one bit so that wait_states=0 still builds.
  localparam int CNT_W = (wait_states > 0) ? $clog2(wait_states + 1) : 1;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;

  logic                  r_last;
  logic                  r_owner;
  logic                  r_op_we;
  logic [CNT_W-1:0]      r_cnt;
  logic [addr_width-1:0] r_ram_addr;
  logic [word_width-1:0] r_ram_wdata;
  logic [word_width-1:0] r_rdata0;
  logic [word_width-1:0] r_rdata1;

  logic                  w_pick_gnt;
  logic                  w_pick_valid;
  logic                  w_grant;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic                  w_rd_capture;
  logic                  w_last_load;
  logic                  w_ram_oe;
  logic                  w_ram_we;
  logic                  w_ack0;
  logic                  w_ack1;
  logic                  w_busy;

  rr_pick2 u_rr_pick2 (
    .i_req   ({bus.req1, bus.req0}),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid)
  );

  // State register; synchronous active-low reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore output decode; strobes and acks come straight from the state register.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_rd_capture = 1'b0;
    w_last_load  = 1'b0;
    w_ram_oe     = 1'b0;
    w_ram_we     = 1'b0;
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;
    w_busy       = 1'b1;

    case (r_state)
      ARB_IDLE: begin
        w_busy = 1'b0;
        if (w_pick_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_ADDR;
        end
      end

      ARB_ADDR: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ARB_ACCESS;
      end

      ARB_ACCESS: begin
        // Reads hold OE for the whole access; writes strobe only once the RAM has had its wait states.
        w_ram_oe = ~r_op_we;
        w_ram_we = r_op_we & (r_cnt == '0);
        if (r_cnt != '0) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_rd_capture = ~r_op_we;
          w_state_nxt  = ARB_DONE;
        end
      end

      ARB_DONE: begin
        w_ack0      = (r_owner == PORT_CPU);
        w_ack1      = (r_owner == PORT_IO);
        w_last_load = 1'b1;
        w_state_nxt = ARB_IDLE;
      end

      default: begin
        // Unreachable with a 2-bit encoding, kept so any corruption falls back quietly.
        w_busy      = 1'b0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Operand latch, wait counter, per-port read data and round-robin memory.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last      <= PORT_IO;
      r_owner     <= PORT_CPU;
      r_op_we     <= 1'b0;
      r_cnt       <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      if (w_grant) begin
        r_owner     <= w_pick_gnt;
        r_op_we     <= (w_pick_gnt == PORT_IO) ? bus.we1    : bus.we0;
        r_ram_addr  <= (w_pick_gnt == PORT_IO) ? bus.addr1  : bus.addr0;
        r_ram_wdata <= (w_pick_gnt == PORT_IO) ? bus.wdata1 : bus.wdata0;
      end

      if (w_cnt_load) begin
        r_cnt <= CNT_W'(wait_states);
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Only the owner's read register moves; the other port keeps its last word.
      if (w_rd_capture) begin
        if (r_owner == PORT_IO) begin
          r_rdata1 <= bus.ram_rdata;
        end else begin
          r_rdata0 <= bus.ram_rdata;
        end
      end

      if (w_last_load) begin
        r_last <= r_owner;
      end
    end
  end

  assign bus.ack0      = w_ack0;
  assign bus.ack1      = w_ack1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_oe    = w_ram_oe;
  assign bus.ram_we    = w_ram_we;

  assign busy       = w_busy;
  assign owner      = r_owner;
  assign disp_state = state_width'(r_state);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: DUT A runs with one wait state, DUT B with none.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        busy_a, owner_a, busy_b, owner_b;
  logic [15:0] disp_a, disp_b;

  mem_bus_arbiter_if #(.word_width(16), .addr_width(16)) bus_a ();
  mem_bus_arbiter_if #(.word_width(16), .addr_width(16)) bus_b ();

  mem_bus_arbiter #(.word_width(16), .addr_width(16), .wait_states(1), .state_width(16)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a),
    .busy       (busy_a),
    .owner      (owner_a),
    .disp_state (disp_a)
  );

  mem_bus_arbiter #(.word_width(16), .addr_width(16), .wait_states(0), .state_width(16)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b),
    .busy       (busy_b),
    .owner      (owner_b),
    .disp_state (disp_b)
  );

  always #5 clk = ~clk;

  // RAM contents: one fixed word, everything else derived from the address.
  function automatic logic [15:0] ram_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign bus_a.ram_rdata = ram_model(bus_a.ram_addr);
  assign bus_b.ram_rdata = ram_model(bus_b.ram_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.req0 = 0; bus_a.we0 = 0; bus_a.addr0 = '0; bus_a.wdata0 = '0;
    bus_a.req1 = 0; bus_a.we1 = 0; bus_a.addr1 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = '0; bus_b.wdata0 = '0;
    bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = '0; bus_b.wdata1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  // Reset held two cycles with both ports requesting: everything quiet and zero.
  task automatic test_reset();
    clear_inputs();
    bus_a.req0 = 1; bus_a.req1 = 1; bus_b.req0 = 1; bus_b.req1 = 1;
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({bus_a.ack0, bus_a.ack1, bus_a.ram_oe, bus_a.ram_we, busy_a, owner_a, disp_a} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_ctrl_a cycle %0d got=%h exp=0", i,
                 {bus_a.ack0, bus_a.ack1, bus_a.ram_oe, bus_a.ram_we, busy_a, owner_a, disp_a});
      end
      n_tests++;
      if ({bus_a.rdata0, bus_a.rdata1, bus_a.ram_addr, bus_a.ram_wdata} !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_data_a cycle %0d got=%h exp=0", i,
                 {bus_a.rdata0, bus_a.rdata1, bus_a.ram_addr, bus_a.ram_wdata});
      end
      n_tests++;
      if ({bus_b.ack0, bus_b.ack1, bus_b.ram_oe, bus_b.ram_we, busy_b, owner_b, disp_b,
           bus_b.rdata0, bus_b.rdata1, bus_b.ram_addr, bus_b.ram_wdata} !== 86'd0) begin
        n_fail++;
        $display("FAIL reset_b cycle %0d got=%h exp=0", i,
                 {bus_b.ack0, bus_b.ack1, bus_b.ram_oe, bus_b.ram_we, busy_b, owner_b, disp_b,
                  bus_b.rdata0, bus_b.rdata1, bus_b.ram_addr, bus_b.ram_wdata});
      end
    end
    clear_inputs();
    rst = 1;
    tick();
  endtask

  // Port 0 read with one wait state: OE in cycles 2-3, ack0 in cycle 4, rdata0 = BEEF.
  task automatic test_single_read();
    logic [4:0] got, exp;
    do_reset();
    bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      got = {bus_a.ram_oe, bus_a.ram_we, bus_a.ack0, bus_a.ack1, busy_a};
      exp = {(c == 2 || c == 3), 1'b0, (c == 4), 1'b0, (c <= 4)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL read_ctrl cycle %0d got oe/we/ack0/ack1/busy=%b exp=%b", c, got, exp);
      end
      if (c == 1) begin
        n_tests++;
        if ({bus_a.ram_addr, owner_a, disp_a} !== {16'h0010, 1'b0, 16'd1}) begin
          n_fail++;
          $display("FAIL read_addr_phase got addr=%h owner=%b state=%0d exp addr=0010 owner=0 state=1",
                   bus_a.ram_addr, owner_a, disp_a);
        end
      end
      if (c == 4 || c == 5) begin
        n_tests++;
        if (bus_a.rdata0 !== 16'hBEEF || bus_a.rdata1 !== 16'h0000) begin
          n_fail++;
          $display("FAIL read_data cycle %0d got rdata0=%h rdata1=%h exp beef/0000", c, bus_a.rdata0, bus_a.rdata1);
        end
      end
      if (c == 4) bus_a.req0 = 0;
    end
  endtask

  // Port 1 write with no wait states: WE only in cycle 2, ack1 in cycle 3, address held afterwards.
  task automatic test_single_write();
    logic [4:0] got, exp;
    do_reset();
    bus_b.req1 = 1; bus_b.we1 = 1; bus_b.addr1 = 16'h0020; bus_b.wdata1 = 16'h1234;
    for (int c = 1; c <= 4; c++) begin
      tick();
      got = {bus_b.ram_oe, bus_b.ram_we, bus_b.ack0, bus_b.ack1, busy_b};
      exp = {1'b0, (c == 2), 1'b0, (c == 3), (c <= 3)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL write_ctrl cycle %0d got oe/we/ack0/ack1/busy=%b exp=%b", c, got, exp);
      end
      if (c == 1) begin
        n_tests++;
        if (owner_b !== 1'b1) begin
          n_fail++;
          $display("FAIL write_owner got=%b exp=1", owner_b);
        end
      end
      if (c == 2 || c == 4) begin
        n_tests++;
        if ({bus_b.ram_addr, bus_b.ram_wdata} !== {16'h0020, 16'h1234}) begin
          n_fail++;
          $display("FAIL write_bus cycle %0d got addr=%h wdata=%h exp 0020/1234", c, bus_b.ram_addr, bus_b.ram_wdata);
        end
      end
      if (c == 3) begin
        bus_b.req1 = 0; bus_b.we1 = 0;
      end
    end
  endtask

  // Both ports requesting from reset: acks alternate 0,1,0,1 every 5 cycles starting at cycle 4.
  task automatic test_tie_alternate();
    int   n_acks;
    logic p;
    n_acks = 0;
    do_reset();
    bus_a.req0 = 1; bus_a.addr0 = 16'h0100;
    bus_a.req1 = 1; bus_a.addr1 = 16'h0200;
    for (int cyc = 1; cyc <= 40 && n_acks < 4; cyc++) begin
      tick();
      if (bus_a.ack0 || bus_a.ack1) begin
        p = n_acks[0];
        n_tests++;
        if ({bus_a.ack0, bus_a.ack1, owner_a} !== {~p, p, p} || cyc != 4 + 5 * n_acks) begin
          n_fail++;
          $display("FAIL tie_ack%0d got ack0/ack1/owner=%b cycle=%0d exp=%b cycle=%0d",
                   n_acks, {bus_a.ack0, bus_a.ack1, owner_a}, cyc, {~p, p, p}, 4 + 5 * n_acks);
        end
        n_acks++;
      end
    end
    bus_a.req0 = 0; bus_a.req1 = 0;
    n_tests++;
    if (n_acks != 4) begin
      n_fail++;
      $display("FAIL tie_count got=%0d acks exp=4", n_acks);
    end
    n_tests++;
    if ({bus_a.rdata0, bus_a.rdata1} !== {16'h5B5A, 16'h585A}) begin
      n_fail++;
      $display("FAIL tie_rdata got=%h/%h exp=5b5a/585a", bus_a.rdata0, bus_a.rdata1);
    end
    tick();
  endtask

  // req0 withdrawn in ADDR: ack0 still at cycle 4, waiting req1 served with ack at cycle 9.
  task automatic test_drop_mid();
    int ack0_cyc, ack1_cyc, ack0_n, ack1_n;
    ack0_cyc = -1; ack1_cyc = -1; ack0_n = 0; ack1_n = 0;
    do_reset();
    bus_a.req0 = 1; bus_a.addr0 = 16'h0300;
    bus_a.req1 = 1; bus_a.addr1 = 16'h0400;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        n_tests++;
        if ({owner_a, disp_a} !== {1'b0, 16'd1}) begin
          n_fail++;
          $display("FAIL drop_grant got owner=%b state=%0d exp owner=0 state=1", owner_a, disp_a);
        end
        bus_a.req0 = 0;
      end
      if (bus_a.ack0) begin ack0_n++; ack0_cyc = c; end
      if (bus_a.ack1) begin ack1_n++; ack1_cyc = c; bus_a.req1 = 0; end
    end
    n_tests++;
    if (ack0_n != 1 || ack0_cyc != 4) begin
      n_fail++;
      $display("FAIL drop_ack0 got count=%0d cycle=%0d exp count=1 cycle=4", ack0_n, ack0_cyc);
    end
    n_tests++;
    if (ack1_n != 1 || ack1_cyc != 9) begin
      n_fail++;
      $display("FAIL drop_ack1 got count=%0d cycle=%0d exp count=1 cycle=9", ack1_n, ack1_cyc);
    end
    n_tests++;
    if ({bus_a.rdata0, bus_a.rdata1} !== {16'h595A, 16'h5E5A}) begin
      n_fail++;
      $display("FAIL drop_rdata got=%h/%h exp=595a/5e5a", bus_a.rdata0, bus_a.rdata1);
    end
  endtask

  // Reset in the first ACCESS cycle of a write: no WE, no ack; a fresh read is granted right after release.
  task automatic test_reset_mid_write();
    do_reset();
    bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 16'h0030; bus_a.wdata0 = 16'h7777;
    tick();
    tick();
    n_tests++;
    if ({disp_a, bus_a.ram_we, bus_a.ram_addr, bus_a.ram_wdata} !== {16'd2, 1'b0, 16'h0030, 16'h7777}) begin
      n_fail++;
      $display("FAIL rstw_access got state=%0d we=%b addr=%h wdata=%h exp 2/0/0030/7777",
               disp_a, bus_a.ram_we, bus_a.ram_addr, bus_a.ram_wdata);
    end
    rst = 0;
    bus_a.req0 = 0; bus_a.we0 = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({bus_a.ram_we, bus_a.ram_oe, bus_a.ack0, bus_a.ack1, busy_a, disp_a} !== 21'd0) begin
        n_fail++;
        $display("FAIL rstw_quiet cycle %0d got=%h exp=0", i,
                 {bus_a.ram_we, bus_a.ram_oe, bus_a.ack0, bus_a.ack1, busy_a, disp_a});
      end
    end
    rst = 1;
    bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 16'h0040;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        n_tests++;
        if ({busy_a, owner_a, disp_a, bus_a.ram_addr} !== {1'b1, 1'b0, 16'd1, 16'h0040}) begin
          n_fail++;
          $display("FAIL rstw_regrant got busy=%b owner=%b state=%0d addr=%h exp 1/0/1/0040",
                   busy_a, owner_a, disp_a, bus_a.ram_addr);
        end
      end
      n_tests++;
      if (bus_a.ack0 !== (c == 4)) begin
        n_fail++;
        $display("FAIL rstw_ack cycle %0d got=%b exp=%b", c, bus_a.ack0, (c == 4));
      end
      if (c == 4) begin
        n_tests++;
        if (bus_a.rdata0 !== 16'h5A1A) begin
          n_fail++;
          $display("FAIL rstw_rdata got=%h exp=5a1a", bus_a.rdata0);
        end
        bus_a.req0 = 0;
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_tie_alternate();
    test_drop_mid();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
